// File: rtl/async_fifo_pkg.sv
// Shared constants and pointer-compare helpers for async_fifo.
// Optional build macro: ASYNC_FIFO_LEVEL_EN (adds the 'level' output).
package async_fifo_pkg;

   localparam int DEF_ADDR_WIDTH = 2;
   localparam int DEF_DATA_WIDTH = 16;
   localparam int PTR_WIDTH      = DEF_ADDR_WIDTH + 1;

   // Widest pointer the helpers handle: BUFFER_ADDR_WIDTH tops out at 12.
   localparam int PTR_MAX        = 13;

   // Pointers are equal in every bit, wrap bit included.
   function automatic logic ptr_empty(input logic [PTR_MAX-1:0] wp,
                                      input logic [PTR_MAX-1:0] rp);
      return wp == rp;
   endfunction

   // Low aw bits match and the wrap bit (bit aw) differs. Callers
   // zero-extend, so every bit above the wrap bit matches.
   function automatic logic ptr_full(input logic [PTR_MAX-1:0] wp,
                                     input logic [PTR_MAX-1:0] rp,
                                     input int aw);
      return (wp ^ rp) == (PTR_MAX'(1) << aw);
   endfunction

endpackage

// File: rtl/async_fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module async_fifo_mem #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 16
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [2**ADDR_W];

   // Store the pushed word; contents survive reset on purpose.
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/async_fifo.sv
// First-word-fall-through FIFO, single clock, async active-low reset.
// Optional build macro: ASYNC_FIFO_LEVEL_EN exposes the occupancy 'level'.
module async_fifo
   import async_fifo_pkg::*;
#(
   parameter int BUFFER_ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH        = DEF_DATA_WIDTH
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        write,
   input  logic [DATA_WIDTH-1:0]       write_data,
   output logic                        can_write,
   input  logic                        read,
   output logic [DATA_WIDTH-1:0]       read_data,
   output logic                        can_read
`ifdef ASYNC_FIFO_LEVEL_EN
   ,
   output logic [BUFFER_ADDR_WIDTH:0]  level
`endif
);

   localparam int PW = BUFFER_ADDR_WIDTH + 1;

   logic [PW-1:0] r_wp;
   logic [PW-1:0] r_rp;
   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;

   // Flags come from the registered pointers only, never from read/write.
   assign w_empty   = ptr_empty(PTR_MAX'(r_wp), PTR_MAX'(r_rp));
   assign w_full    = ptr_full(PTR_MAX'(r_wp), PTR_MAX'(r_rp), BUFFER_ADDR_WIDTH);
   assign can_read  = !w_empty;
   assign can_write = !w_full;
   assign w_push    = write && !w_full;
   assign w_pop     = read && !w_empty;

   // Pointers wrap naturally at 2^PW; reset drops all buffered words.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wp <= '0;
         r_rp <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_pop)  r_rp <= r_rp + 1'b1;
      end
   end

   async_fifo_mem #(
      .ADDR_W (BUFFER_ADDR_WIDTH),
      .DATA_W (DATA_WIDTH)
   ) u_mem (
      .i_clk   (clk),
      .i_we    (w_push),
      .i_waddr (r_wp[BUFFER_ADDR_WIDTH-1:0]),
      .i_wdata (write_data),
      .i_raddr (r_rp[BUFFER_ADDR_WIDTH-1:0]),
      .o_rdata (read_data)
   );

`ifdef ASYNC_FIFO_LEVEL_EN
   // Modular difference gives 0..depth, including the full case.
   assign level = r_wp - r_rp;
`endif

endmodule

// File: tb/tb_async_fifo.sv
// Directed bench for async_fifo (depth 4, 16-bit words).
module tb_async_fifo;
   import async_fifo_pkg::*;

   logic        clk;
   logic        reset;
   logic        write;
   logic [15:0] write_data;
   logic        can_write;
   logic        read;
   logic [15:0] read_data;
   logic        can_read;
`ifdef ASYNC_FIFO_LEVEL_EN
   logic [2:0]  level;
`endif

   int checks;
   int fails;

   async_fifo #(.BUFFER_ADDR_WIDTH(2), .DATA_WIDTH(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .write      (write),
      .write_data (write_data),
      .can_write  (can_write),
      .read       (read),
      .read_data  (read_data),
      .can_read   (can_read)
`ifdef ASYNC_FIFO_LEVEL_EN
      ,
      .level      (level)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock with the given request levels; outputs settle #1 after the edge.
   task automatic step(input logic w, input logic [15:0] wd, input logic r);
      write = w; write_data = wd; read = r;
      @(posedge clk);
      #1;
      write = 1'b0; read = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; write = 1'b0; read = 1'b0; write_data = 16'h0;
      #3;
      checks++; if (can_read !== 1'b0) begin fails++; $display("FAIL rst_can_read got=%b want=0", can_read); end
      checks++; if (can_write !== 1'b1) begin fails++; $display("FAIL rst_can_write got=%b want=1", can_write); end
      @(posedge clk); #2;
      reset = 1'b1;
      step(1'b0, 16'h0, 1'b0);
      step(1'b0, 16'h0, 1'b0);
      checks++; if (can_read !== 1'b0) begin fails++; $display("FAIL idle_can_read got=%b want=0", can_read); end
      checks++; if (can_write !== 1'b1) begin fails++; $display("FAIL idle_can_write got=%b want=1", can_write); end
`ifdef ASYNC_FIFO_LEVEL_EN
      checks++; if (level !== 3'd0) begin fails++; $display("FAIL idle_level got=%0d want=0", level); end
`endif
   endtask

   task automatic test_fill_overflow();
      logic [15:0] vals [4];
      vals[0] = 16'hdead; vals[1] = 16'hbeef; vals[2] = 16'hfeed; vals[3] = 16'hface;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, vals[i], 1'b0);
         checks++; if (can_read !== 1'b1 || read_data !== 16'hdead)
            begin fails++; $display("FAIL fill%0d got=%b/%h want=1/dead", i, can_read, read_data); end
         checks++; if (can_write !== (i != 3))
            begin fails++; $display("FAIL fill%0d_can_write got=%b want=%b", i, can_write, (i != 3)); end
      end
      step(1'b1, 16'hd00b, 1'b0);
      checks++; if (can_write !== 1'b0 || read_data !== 16'hdead)
         begin fails++; $display("FAIL overflow got=%b/%h want=0/dead", can_write, read_data); end
`ifdef ASYNC_FIFO_LEVEL_EN
      checks++; if (level !== 3'd4) begin fails++; $display("FAIL full_level got=%0d want=4", level); end
`endif
   endtask

   task automatic test_drain();
      logic [15:0] vals [4];
      vals[0] = 16'hdead; vals[1] = 16'hbeef; vals[2] = 16'hfeed; vals[3] = 16'hface;
      for (int i = 0; i < 4; i++) begin
         checks++; if (can_read !== 1'b1 || read_data !== vals[i])
            begin fails++; $display("FAIL drain%0d got=%b/%h want=1/%h", i, can_read, read_data, vals[i]); end
         step(1'b0, 16'h0, 1'b1);
      end
      checks++; if (can_read !== 1'b0 || can_write !== 1'b1)
         begin fails++; $display("FAIL drained got=%b/%b want=0/1", can_read, can_write); end
      step(1'b0, 16'h0, 1'b1);
      checks++; if (can_read !== 1'b0 || can_write !== 1'b1)
         begin fails++; $display("FAIL underflow got=%b/%b want=0/1", can_read, can_write); end
   endtask

   task automatic test_wrap();
      logic [15:0] v;
      for (int i = 0; i < 9; i++) begin
         v = 16'hf00f + 16'(i);
         step(1'b1, v, 1'b0);
         checks++; if (can_read !== 1'b1 || read_data !== v)
            begin fails++; $display("FAIL wrap%0d got=%b/%h want=1/%h", i, can_read, read_data, v); end
         step(1'b0, 16'h0, 1'b1);
         checks++; if (can_read !== 1'b0)
            begin fails++; $display("FAIL wrap%0d_empty got=%b want=0", i, can_read); end
      end
   endtask

   task automatic test_simultaneous();
      logic [15:0] vals [4];
      vals[0] = 16'ha000; vals[1] = 16'ha001; vals[2] = 16'ha002; vals[3] = 16'ha003;
      for (int i = 0; i < 4; i++) step(1'b1, vals[i], 1'b0);
      checks++; if (can_write !== 1'b0) begin fails++; $display("FAIL simfull_pre got=%b want=0", can_write); end
      step(1'b1, 16'h5555, 1'b1);
      checks++; if (can_write !== 1'b1 || read_data !== 16'ha001)
         begin fails++; $display("FAIL simfull got=%b/%h want=1/a001", can_write, read_data); end
`ifdef ASYNC_FIFO_LEVEL_EN
      checks++; if (level !== 3'd3) begin fails++; $display("FAIL simfull_level got=%0d want=3", level); end
`endif
      for (int i = 1; i < 4; i++) begin
         checks++; if (can_read !== 1'b1 || read_data !== vals[i])
            begin fails++; $display("FAIL simdrain%0d got=%b/%h want=1/%h", i, can_read, read_data, vals[i]); end
         step(1'b0, 16'h0, 1'b1);
      end
      checks++; if (can_read !== 1'b0) begin fails++; $display("FAIL simdrain_empty got=%b want=0", can_read); end
      step(1'b1, 16'h7777, 1'b1);
      checks++; if (can_read !== 1'b1 || read_data !== 16'h7777)
         begin fails++; $display("FAIL simempty got=%b/%h want=1/7777", can_read, read_data); end
      step(1'b0, 16'h0, 1'b1);
      checks++; if (can_read !== 1'b0) begin fails++; $display("FAIL simempty_pop got=%b want=0", can_read); end
   endtask

   task automatic test_mid_reset();
      step(1'b1, 16'h0111, 1'b0);
      step(1'b1, 16'h0222, 1'b0);
      step(1'b1, 16'h0333, 1'b0);
      checks++; if (can_read !== 1'b1) begin fails++; $display("FAIL pre_reset got=%b want=1", can_read); end
      #2 reset = 1'b0;
      #1;
      checks++; if (can_read !== 1'b0 || can_write !== 1'b1)
         begin fails++; $display("FAIL async_reset got=%b/%b want=0/1", can_read, can_write); end
`ifdef ASYNC_FIFO_LEVEL_EN
      checks++; if (level !== 3'd0) begin fails++; $display("FAIL reset_level got=%0d want=0", level); end
`endif
      #2 reset = 1'b1;
      @(posedge clk); #1;
      step(1'b1, 16'h1234, 1'b0);
      checks++; if (can_read !== 1'b1 || read_data !== 16'h1234)
         begin fails++; $display("FAIL post_reset got=%b/%h want=1/1234", can_read, read_data); end
      step(1'b0, 16'h0, 1'b1);
      checks++; if (can_read !== 1'b0) begin fails++; $display("FAIL post_reset_pop got=%b want=0", can_read); end
   endtask

   initial begin
      checks = 0;
      fails  = 0;
      test_reset();
      test_fill_overflow();
      test_drain();
      test_wrap();
      test_simultaneous();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
